// File: rtl/irq_ctl.sv
// irq_ctl: memory-mapped interrupt controller for the beta core.
// External lines are synchronised and edge-detected into a pending register.
// A down-counting timer adds one more pending source at index N_SRC.
// Software masks, clears and inspects sources through a 32-byte register window.
// Register state is clocked. Bus reads are combinational to suit a single-cycle core.
module irq_ctl #(
    parameter logic [31:0] BASE  = 32'hFFFF0000,
    parameter int          N_SRC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] ext_irq,
    input  logic [31:0]      memAddr,
    input  logic [31:0]      memWriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic             sel,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_MASK    = 3'd1;
    localparam logic [2:0] OFF_CTRL    = 3'd2;
    localparam logic [2:0] OFF_TLOAD   = 3'd3;
    localparam logic [2:0] OFF_TCOUNT  = 3'd4;
    localparam logic [2:0] OFF_CAUSE   = 3'd5;

    localparam int PAD = 31 - N_SRC;

    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;
    logic [N_SRC-1:0] hist;
    logic [N_SRC-1:0] rise;

    logic [N_SRC:0]   pending;
    logic [N_SRC:0]   mask;
    logic [N_SRC:0]   active;
    logic [N_SRC:0]   hw_set;
    logic [N_SRC:0]   w1c;

    logic             ctrl_gie;
    logic             ctrl_ten;
    logic             ctrl_trel;
    logic [31:0]      tload;
    logic [31:0]      tcount;
    logic             expire;

    logic [2:0]       offset;
    logic             wr_en;
    logic             wr_pending;
    logic             wr_mask;
    logic             wr_ctrl;
    logic             wr_tload;
    logic             wr_tcount;

    logic             cause_valid;
    logic [3:0]       cause_idx;

    // The window is 32 bytes, so only the upper 27 address bits take part in the decode.
    assign sel    = (memAddr[31:5] == BASE[31:5]);
    assign offset = memAddr[4:2];

    // Only aligned stores commit. A cycle that strobes both read and write is dropped as malformed.
    assign wr_en      = MemWrite & ~MemRead & sel & (memAddr[1:0] == 2'b00);
    assign wr_pending = wr_en & (offset == OFF_PENDING);
    assign wr_mask    = wr_en & (offset == OFF_MASK);
    assign wr_ctrl    = wr_en & (offset == OFF_CTRL);
    assign wr_tload   = wr_en & (offset == OFF_TLOAD);
    assign wr_tcount  = wr_en & (offset == OFF_TCOUNT);

    assign rise   = sync2 & ~hist;
    assign expire = ctrl_ten & (tcount == 32'd0);
    assign hw_set = {expire, rise};
    assign w1c    = wr_pending ? memWriteData[N_SRC:0] : '0;

    assign active = pending & mask;
    assign irq    = ctrl_gie & (|active);

    // Two-flop synchroniser followed by a history flop, so each rising edge is seen exactly once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= ext_irq;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Pending bits latch hardware events. A set arriving with a W1C for the same bit wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~w1c) | hw_set;
        end
    end

    // Per-source enable mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
        end else if (wr_mask) begin
            mask <= memWriteData[N_SRC:0];
        end
    end

    // Control bits. A one-shot timer clears TEN on expiry unless software rewrites CTRL in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_gie  <= 1'b0;
            ctrl_ten  <= 1'b0;
            ctrl_trel <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_gie  <= memWriteData[0];
            ctrl_ten  <= memWriteData[1];
            ctrl_trel <= memWriteData[2];
        end else if (expire && !ctrl_trel) begin
            ctrl_ten  <= 1'b0;
        end
    end

    // Reload value. It is used only when the counter expires, so writing it never disturbs the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tload <= '0;
        end else if (wr_tload) begin
            tload <= memWriteData;
        end
    end

    // Down-counter. A direct software load beats both the decrement and the reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcount <= '0;
        end else if (wr_tcount) begin
            tcount <= memWriteData;
        end else if (ctrl_ten) begin
            if (tcount != 32'd0) begin
                tcount <= tcount - 32'd1;
            end else if (ctrl_trel) begin
                tcount <= tload;
            end
        end
    end

    // Find the lowest enabled pending source. Scanning downward lets the lowest index overwrite the result last.
    always_comb begin
        cause_valid = 1'b0;
        cause_idx   = 4'd0;
        for (int i = N_SRC; i >= 0; i--) begin
            if (active[i]) begin
                cause_valid = 1'b1;
                cause_idx   = 4'(i);
            end
        end
    end

    // Combinational read mux. It returns zero unless a load targets the window.
    always_comb begin
        rdata = 32'd0;
        if (sel && MemRead) begin
            case (offset)
                OFF_PENDING: rdata = {{PAD{1'b0}}, pending};
                OFF_MASK:    rdata = {{PAD{1'b0}}, mask};
                OFF_CTRL:    rdata = {29'd0, ctrl_trel, ctrl_ten, ctrl_gie};
                OFF_TLOAD:   rdata = tload;
                OFF_TCOUNT:  rdata = tcount;
                OFF_CAUSE:   rdata = {cause_valid, 27'd0, cause_idx};
                default:     rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed self-checking bench for irq_ctl.
// Each task drives one scenario and compares against hand-computed values.
module tb_irq_ctl;

    localparam logic [31:0] A_PEND  = 32'hFFFF0000;
    localparam logic [31:0] A_MASK  = 32'hFFFF0004;
    localparam logic [31:0] A_CTRL  = 32'hFFFF0008;
    localparam logic [31:0] A_TLOAD = 32'hFFFF000C;
    localparam logic [31:0] A_TCNT  = 32'hFFFF0010;
    localparam logic [31:0] A_CAUSE = 32'hFFFF0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ext_irq = 8'h00;
    logic [31:0] memAddr = 32'd0;
    logic [31:0] memWriteData = 32'd0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        sel;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad = 0;

    irq_ctl #(.BASE(32'hFFFF0000), .N_SRC(8)) dut (
        .clk(clk),
        .reset(reset),
        .ext_irq(ext_irq),
        .memAddr(memAddr),
        .memWriteData(memWriteData),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .sel(sel),
        .rdata(rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memAddr = a;
        memWriteData = d;
        MemRead = 1'b0;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        memAddr = a;
        MemRead = 1'b1;
        #1;
        d = rdata;
        MemRead = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        ext_irq = 8'h01;
        reset = 1'b0;
        #3;
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%0b want=0", irq); end
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL reset_pending got=%h want=0", v); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL sync_early got=%h want=0", v); end
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h001) begin bad++; $display("[TB] FAIL sync_set got=%h want=001", v); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_masked got=%0b want=0", irq); end
        bus_write(A_MASK, 32'h1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_no_gie got=%0b want=0", irq); end
        bus_write(A_CTRL, 32'h1);
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_enabled got=%0b want=1", irq); end
        repeat (3) @(posedge clk);
        #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h001) begin bad++; $display("[TB] FAIL level_once got=%h want=001", v); end
    endtask

    task automatic test_w1c;
        logic [31:0] v;
        ext_irq = 8'h00;
        repeat (3) @(posedge clk);
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL w1c_plain got=%h want=0", v); end
        @(negedge clk);
        ext_irq = 8'h01;
        @(posedge clk);
        @(posedge clk);
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h001) begin bad++; $display("[TB] FAIL set_beats_w1c got=%h want=001", v); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_before_clr got=%0b want=1", irq); end
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL w1c_clear got=%h want=0", v); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_after_clr got=%0b want=0", irq); end
    endtask

    task automatic test_timer_reload;
        logic [31:0] v;
        logic [31:0] exp_cnt [1:4];
        exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1; exp_cnt[3] = 32'd0; exp_cnt[4] = 32'd3;
        bus_write(A_PEND, 32'h1FF);
        bus_write(A_MASK, 32'h100);
        bus_write(A_TLOAD, 32'd3);
        bus_write(A_TCNT, 32'd3);
        bus_write(A_CTRL, 32'h7);
        bus_read(A_TCNT, v);
        total++;
        if (v !== 32'd3) begin bad++; $display("[TB] FAIL tcnt_start got=%0d want=3", v); end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            bus_read(A_TCNT, v);
            total++;
            if (v !== exp_cnt[i]) begin bad++; $display("[TB] FAIL tcnt_step%0d got=%0d want=%0d", i, v, exp_cnt[i]); end
            bus_read(A_PEND, v);
            total++;
            if (v !== ((i == 4) ? 32'h100 : 32'h0)) begin
                bad++; $display("[TB] FAIL tpend_step%0d got=%h want=%h", i, v, (i == 4) ? 32'h100 : 32'h0);
            end
        end
        bus_read(A_CAUSE, v);
        total++;
        if (v !== 32'h80000008) begin bad++; $display("[TB] FAIL cause_timer got=%h want=80000008", v); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_timer got=%0b want=1", irq); end
        bus_write(A_PEND, 32'h100);
        bus_read(A_TCNT, v);
        total++;
        if (v !== 32'd2) begin bad++; $display("[TB] FAIL tcnt_after_clr got=%0d want=2", v); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("[TB] FAIL tpend_gap got=%h want=0", v); end
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h100) begin bad++; $display("[TB] FAIL tpend_period got=%h want=100", v); end
        bus_write(A_CTRL, 32'h1);
    endtask

    task automatic test_timer_oneshot;
        logic [31:0] v;
        int zero_bad;
        bus_write(A_PEND, 32'h1FF);
        bus_write(A_TCNT, 32'd2);
        bus_write(A_CTRL, 32'h3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("[TB] FAIL oneshot_early got=%h want=0", v); end
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h100) begin bad++; $display("[TB] FAIL oneshot_pend got=%h want=100", v); end
        bus_read(A_CTRL, v);
        total++;
        if (v !== 32'h1) begin bad++; $display("[TB] FAIL oneshot_ctrl got=%h want=1", v); end
        zero_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus_read(A_TCNT, v);
            if (v !== 32'd0) zero_bad++;
        end
        total++;
        if (zero_bad != 0) begin bad++; $display("[TB] FAIL oneshot_hold got=%0d nonzero cycles want=0", zero_bad); end
        bus_write(A_TLOAD, 32'd7);
        bus_read(A_TCNT, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL tload_no_touch got=%0d want=0", v); end
    endtask

    task automatic test_ext_cause;
        logic [31:0] v;
        bus_write(A_PEND, 32'h1FF);
        bus_write(A_MASK, 32'h0FF);
        @(negedge clk);
        ext_irq = 8'h25;
        @(posedge clk);
        @(negedge clk);
        ext_irq = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h024) begin bad++; $display("[TB] FAIL ext_pend got=%h want=024", v); end
        bus_read(A_CAUSE, v);
        total++;
        if (v !== 32'h80000002) begin bad++; $display("[TB] FAIL cause_two got=%h want=80000002", v); end
        bus_write(A_PEND, 32'h004);
        bus_read(A_CAUSE, v);
        total++;
        if (v !== 32'h80000005) begin bad++; $display("[TB] FAIL cause_five got=%h want=80000005", v); end
    endtask

    task automatic test_bus_decode;
        logic [31:0] v;
        bus_read(32'hFFFF0018, v);
        total++;
        if (sel !== 1'b1 || v !== 32'd0) begin bad++; $display("[TB] FAIL hole_read sel=%0b rdata=%h want sel=1 rdata=0", sel, v); end
        bus_read(32'h00001000, v);
        total++;
        if (sel !== 1'b0 || v !== 32'd0) begin bad++; $display("[TB] FAIL outside sel=%0b rdata=%h want sel=0 rdata=0", sel, v); end
        memAddr = A_MASK;
        MemRead = 1'b0;
        #1;
        total++;
        if (rdata !== 32'd0) begin bad++; $display("[TB] FAIL no_strobe got=%h want=0", rdata); end
        bus_write(32'hFFFF0006, 32'h0);
        bus_read(A_MASK, v);
        total++;
        if (v !== 32'h0FF) begin bad++; $display("[TB] FAIL misaligned got=%h want=0ff", v); end
        @(negedge clk);
        memAddr = A_MASK;
        memWriteData = 32'h0;
        MemRead = 1'b1;
        MemWrite = 1'b1;
        @(posedge clk); #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        bus_read(A_MASK, v);
        total++;
        if (v !== 32'h0FF) begin bad++; $display("[TB] FAIL rd_wr_both got=%h want=0ff", v); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_irq got=%0b want=1", irq); end
        reset = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL async_irq got=%0b want=0", irq); end
        bus_read(A_CTRL, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL async_ctrl got=%h want=0", v); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL rel_early got=%h want=0", v); end
        @(posedge clk); #1;
        bus_read(A_PEND, v);
        total++;
        if (v !== 32'h001) begin bad++; $display("[TB] FAIL rel_once got=%h want=001", v); end
    endtask

    initial begin
        test_reset();
        test_w1c();
        test_timer_reload();
        test_timer_oneshot();
        test_ext_cause();
        test_bus_decode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
